ex_fsm: RTL and testbench

Execute-stage control FSM directly downstream of the instruction-fetch FSM. It samples the 16-bit instruction register once fetch reports it loaded, decodes it, and sequences the register-file, ALU, PC and memory-interface enables. It then pulses `done`, which returns fetch to its start state for the next instruction.

---
 rtl/ex_pkg.sv | 128 ++++++++++++
 rtl/ex_fsm_mfc_timer.sv | 28 ++
 rtl/ex_fsm.sv | 166 ++++++++++++++++
 tb/tb_ex_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, IR field positions, state encoding and the
// per-state control-word decode shared by the execute FSM.
package ex_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MOVI  = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // LOAD/STORE share the address state; HALT and ERR share one
  // terminal state, told apart by the sticky flag registers.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    LD_MEM   = 4'd3,
    LD_MDR   = 4'd4,
    LD_WB    = 4'd5,
    ST_DATA  = 4'd6,
    ST_MEM   = 4'd7,
    AL_A     = 4'd8,
    AL_B     = 4'd9,
    AL_WB    = 4'd10,
    MV       = 4'd11,
    JP       = 4'd12,
    PC_INC   = 4'd13,
    DONE     = 4'd14,
    STOP     = 4'd15
  } state_t;

  typedef struct packed {
    logic       imm_out;
    logic       mar_en;
    logic       mem_en;
    logic       mem_rw;
    logic       mdr_rd;
    logic       mdr_wr;
    logic       mdr_out;
    logic       reg_out;
    logic       reg_in;
    logic       a_en;
    logic       alu_op;
    logic       alu_en;
    logic       alu_out;
    logic       pc_inc;
    logic       pc_en;
    logic       done;
    logic [3:0] reg_sel;
  } ctl_t;

  function automatic logic [3:0] opc(logic [15:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

  function automatic ctl_t decode_ctl(state_t s, logic [15:0] ir);
    ctl_t c;
    c = '0;
    unique case (s)
      MEM_ADDR: begin
        c.imm_out = 1'b1;
        c.mar_en  = 1'b1;
      end
      LD_MEM: begin
        c.mem_en = 1'b1;
        c.mem_rw = 1'b1;
      end
      LD_MDR: begin
        c.mem_en = 1'b1;
        c.mem_rw = 1'b1;
        c.mdr_rd = 1'b1;
      end
      LD_WB: begin
        c.mdr_out = 1'b1;
        c.reg_in  = 1'b1;
        c.reg_sel = ir[RD_HI:RD_LO];
      end
      ST_DATA: begin
        c.reg_out = 1'b1;
        c.mdr_wr  = 1'b1;
        c.reg_sel = ir[RD_HI:RD_LO];
      end
      ST_MEM: c.mem_en = 1'b1;
      AL_A: begin
        c.reg_out = 1'b1;
        c.a_en    = 1'b1;
        c.reg_sel = ir[RD_HI:RD_LO];
      end
      AL_B: begin
        c.reg_out = 1'b1;
        c.alu_en  = 1'b1;
        c.alu_op  = (opc(ir) == OP_SUB);
        c.reg_sel = ir[RS_HI:RS_LO];
      end
      AL_WB: begin
        c.alu_out = 1'b1;
        c.reg_in  = 1'b1;
        c.reg_sel = ir[RD_HI:RD_LO];
      end
      MV: begin
        c.imm_out = 1'b1;
        c.reg_in  = 1'b1;
        c.reg_sel = ir[RD_HI:RD_LO];
      end
      JP: begin
        c.imm_out = 1'b1;
        c.pc_en   = 1'b1;
      end
      PC_INC: c.pc_inc = 1'b1;
      DONE:   c.done   = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_fsm_mfc_timer.sv
// mfc_timer: counts MFC-low cycles in a memory state; expired
// flags that the wait limit has been reached.
module mfc_timer #(
  parameter int LIMIT = 255,
  parameter int TW    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic MFC,
  output logic expired
);

  logic [TW-1:0] cnt;

  assign expired = (cnt == TW'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && !MFC && !expired)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ex_fsm.sv
// ex_fsm: execute-stage control FSM with registered Moore outputs.
// Define EX_MFC_TIMEOUT_EN to bound memory waits and raise bus_err.
module ex_fsm
  import ex_pkg::*;
#(
  parameter int MFC_TIMEOUT = 255,
  parameter int TW          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_valid,
  input  logic [15:0] ir,
  input  logic        MFC,
  output logic        IMM_out,
  output logic        MAR_EN,
  output logic        mem_EN,
  output logic        mem_RW,
  output logic        MDR_EN_read,
  output logic        MDR_EN_write,
  output logic        MDR_out,
  output logic [3:0]  reg_sel,
  output logic        reg_out,
  output logic        reg_in,
  output logic        A_EN,
  output logic        alu_op,
  output logic        ALU_EN,
  output logic        ALU_out,
  output logic        PC_inc,
  output logic        PC_EN,
  output logic        done,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  state_t      state, nxt;
  logic [15:0] ir_q, ir_n;
  logic        rearm;
  logic        expired;
  logic        halt_set, ill_set, err_set;
  ctl_t        ctl;

  always_comb begin
    nxt      = state;
    ir_n     = ir_q;
    halt_set = 1'b0;
    ill_set  = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      IDLE:
        if (!rearm && ir_valid) begin
          nxt  = DECODE;
          ir_n = ir;
        end
      DECODE:
        unique case (opc(ir_q))
          OP_NOP:          nxt = PC_INC;
          OP_LOAD,
          OP_STORE:        nxt = MEM_ADDR;
          OP_ADD, OP_SUB:  nxt = AL_A;
          OP_MOVI:         nxt = MV;
          OP_JMP:          nxt = JP;
          OP_HALT: begin
            nxt      = STOP;
            halt_set = 1'b1;
          end
          default: begin
            nxt      = STOP;
            halt_set = 1'b1;
            ill_set  = 1'b1;
          end
        endcase
      MEM_ADDR:
        nxt = (opc(ir_q) == OP_LOAD) ? LD_MEM : ST_DATA;
      LD_MEM, ST_MEM:
        if (MFC)
          nxt = (state == LD_MEM) ? LD_MDR : PC_INC;
        else if (expired) begin
          nxt     = STOP;
          err_set = 1'b1;
        end
      LD_MDR:  nxt = LD_WB;
      LD_WB:   nxt = PC_INC;
      ST_DATA: nxt = ST_MEM;
      AL_A:    nxt = AL_B;
      AL_B:    nxt = AL_WB;
      AL_WB:   nxt = PC_INC;
      MV:      nxt = PC_INC;
      JP:      nxt = DONE;
      PC_INC:  nxt = DONE;
      DONE:    nxt = IDLE;
      STOP:    nxt = STOP;
      default: nxt = IDLE;
    endcase
  end

`ifdef EX_MFC_TIMEOUT_EN
  logic in_mem;
  logic bus_err_q;

  assign in_mem  = (state == LD_MEM) || (state == ST_MEM);
  assign bus_err = bus_err_q;

  mfc_timer #(
    .LIMIT (MFC_TIMEOUT),
    .TW    (TW)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_mem),
    .enable  (in_mem),
    .MFC     (MFC),
    .expired (expired)
  );
`else
  logic [TW:0] unused_cfg;

  assign unused_cfg = {err_set, TW'(MFC_TIMEOUT)};
  assign expired    = 1'b0;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ir_q    <= '0;
      rearm   <= 1'b0;
      ctl     <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
`ifdef EX_MFC_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      ir_q    <= ir_n;
      // fetch may still hold ir_valid for the cycle after done
      rearm   <= (state == DONE);
      ctl     <= decode_ctl(nxt, ir_n);
      halted  <= halted | halt_set;
      illegal <= illegal | ill_set;
`ifdef EX_MFC_TIMEOUT_EN
      bus_err_q <= bus_err_q | err_set;
`endif
    end
  end

  assign IMM_out      = ctl.imm_out;
  assign MAR_EN       = ctl.mar_en;
  assign mem_EN       = ctl.mem_en;
  assign mem_RW       = ctl.mem_rw;
  assign MDR_EN_read  = ctl.mdr_rd;
  assign MDR_EN_write = ctl.mdr_wr;
  assign MDR_out      = ctl.mdr_out;
  assign reg_sel      = ctl.reg_sel;
  assign reg_out      = ctl.reg_out;
  assign reg_in       = ctl.reg_in;
  assign A_EN         = ctl.a_en;
  assign alu_op       = ctl.alu_op;
  assign ALU_EN       = ctl.alu_en;
  assign ALU_out      = ctl.alu_out;
  assign PC_inc       = ctl.pc_inc;
  assign PC_EN        = ctl.pc_en;
  assign done         = ctl.done;

endmodule

// File: tb/tb_ex_fsm.sv
// tb_ex_fsm: per-cycle check of ex_fsm control outputs against a
// micro-step table built from the instruction semantics.
module tb_ex_fsm;

`ifdef EX_MFC_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [22:0] IMM   = 23'h1 << 22;
  localparam logic [22:0] MAR   = 23'h1 << 21;
  localparam logic [22:0] MEN   = 23'h1 << 20;
  localparam logic [22:0] MRW   = 23'h1 << 19;
  localparam logic [22:0] MDRR  = 23'h1 << 18;
  localparam logic [22:0] MDRW  = 23'h1 << 17;
  localparam logic [22:0] MDRO  = 23'h1 << 16;
  localparam logic [22:0] RO    = 23'h1 << 15;
  localparam logic [22:0] RI    = 23'h1 << 14;
  localparam logic [22:0] AEN   = 23'h1 << 13;
  localparam logic [22:0] AOP   = 23'h1 << 12;
  localparam logic [22:0] ALUEN = 23'h1 << 11;
  localparam logic [22:0] ALUO  = 23'h1 << 10;
  localparam logic [22:0] PCI   = 23'h1 << 9;
  localparam logic [22:0] PCE   = 23'h1 << 8;
  localparam logic [22:0] DN    = 23'h1 << 7;
  localparam logic [22:0] HLT   = 23'h1 << 6;
  localparam logic [22:0] ILL   = 23'h1 << 5;
  localparam logic [22:0] BERR  = 23'h1 << 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_valid = 1'b0;
  logic [15:0] ir = '0;
  logic        MFC = 1'b0;
  logic        IMM_out, MAR_EN, mem_EN, mem_RW;
  logic        MDR_EN_read, MDR_EN_write, MDR_out;
  logic [3:0]  reg_sel;
  logic        reg_out, reg_in, A_EN, alu_op, ALU_EN, ALU_out;
  logic        PC_inc, PC_EN, done, halted, illegal, bus_err;
  logic [22:0] obs;

  int          checks = 0;
  int          failures = 0;
  logic [22:0] exp_q[$];
  bit          mfc_q[$];
  int          lat;
  bit          stopped;

  ex_fsm #(
    .MFC_TIMEOUT (TO),
    .TW          (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_valid     (ir_valid),
    .ir           (ir),
    .MFC          (MFC),
    .IMM_out      (IMM_out),
    .MAR_EN       (MAR_EN),
    .mem_EN       (mem_EN),
    .mem_RW       (mem_RW),
    .MDR_EN_read  (MDR_EN_read),
    .MDR_EN_write (MDR_EN_write),
    .MDR_out      (MDR_out),
    .reg_sel      (reg_sel),
    .reg_out      (reg_out),
    .reg_in       (reg_in),
    .A_EN         (A_EN),
    .alu_op       (alu_op),
    .ALU_EN       (ALU_EN),
    .ALU_out      (ALU_out),
    .PC_inc       (PC_inc),
    .PC_EN        (PC_EN),
    .done         (done),
    .halted       (halted),
    .illegal      (illegal),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  assign obs = {IMM_out, MAR_EN, mem_EN, mem_RW, MDR_EN_read,
                MDR_EN_write, MDR_out, reg_out, reg_in, A_EN,
                alu_op, ALU_EN, ALU_out, PC_inc, PC_EN, done,
                halted, illegal, bus_err, reg_sel};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [22:0] v);
    exp_q.push_back(v);
    mfc_q.push_back(1'($urandom));
  endtask

  // w cycles of MFC low, then MFC high, unless the timeout fires first
  task automatic mem_wait(input logic [22:0] v, input int w);
    for (int k = 0; k <= w; k++) begin
      exp_q.push_back(v);
      mfc_q.push_back(k == w);
      if (TO_EN && k == TO && k < w) begin
        stopped = 1'b1;
        break;
      end
    end
    if (stopped) repeat (6) put(BERR);
  endtask

  task automatic model(input logic [15:0] instr, input int w);
    logic [3:0]  op;
    logic [22:0] d, s;
    op = instr[15:12];
    d  = 23'(instr[11:8]);
    s  = 23'(instr[7:4]);
    exp_q.delete();
    mfc_q.delete();
    stopped = 1'b0;
    lat = -1;
    case (op)
      4'h0: lat = 3;
      4'h1: begin
        lat = 7 + w;
        put(IMM | MAR);
        mem_wait(MEN | MRW, w);
        if (!stopped) begin
          put(MEN | MRW | MDRR);
          put(MDRO | RI | d);
        end
      end
      4'h2: begin
        lat = 6 + w;
        put(IMM | MAR);
        put(RO | MDRW | d);
        mem_wait(MEN, w);
      end
      4'h3, 4'h4: begin
        lat = 6;
        put(RO | AEN | d);
        put(RO | ALUEN | s | (op == 4'h4 ? AOP : 23'h0));
        put(ALUO | RI | d);
      end
      4'h5: begin
        lat = 4;
        put(IMM | RI | d);
      end
      4'h6: begin
        lat = 3;
        put(IMM | PCE);
      end
      4'hF: begin
        stopped = 1'b1;
        repeat (6) put(HLT);
      end
      default: begin
        stopped = 1'b1;
        repeat (6) put(HLT | ILL);
      end
    endcase
    if (!stopped) begin
      if (op != 4'h6) put(PCI);
      put(DN);
    end
  endtask

  task automatic run(input logic [15:0] instr, input int w,
                     input int gap);
    int dc;
    model(instr, w);
    ir = instr;
    ir_valid = 1'b1;
    MFC = 1'($urandom);
    chk($sformatf("%h c0", instr), 32'(obs), 32'h0);
    tick();
    ir = 16'($urandom);
    MFC = 1'($urandom);
    chk($sformatf("%h c1", instr), 32'(obs), 32'h0);
    tick();
    dc = -1;
    foreach (exp_q[i]) begin
      MFC = mfc_q[i];
      if (stopped) ir_valid = 1'($urandom);
      if (obs[7] && dc < 0) dc = i + 2;
      chk($sformatf("%h c%0d", instr, i + 2), 32'(obs), 32'(exp_q[i]));
      tick();
    end
    if (stopped) begin
      rst = 1'b0;
      #1;
      chk($sformatf("%h stop rst", instr), 32'(obs), 32'h0);
      ir_valid = 1'b0;
      tick();
      rst = 1'b1;
    end else begin
      chk($sformatf("%h latency", instr), 32'(dc), 32'(lat));
      chk($sformatf("%h rearm", instr), 32'(obs), 32'h0);
      tick();
      ir_valid = 1'b0;
      repeat (gap) begin
        chk("idle gap", 32'(obs), 32'h0);
        tick();
      end
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 chk("reset", 32'(obs), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    run(16'h1320, 3, 1);
    run(16'h3120, 0, 0);
    run(16'h60A5, 0, 2);
    run(16'h4213, 1, 0);
    run(16'h5A7C, 0, 1);
    run(16'h0000, 0, 0);
    run(16'h2455, 300, 1);

    ir = 16'h3120;
    ir_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("al_b", 32'(obs), 32'(RO | ALUEN | 23'h2));
    rst = 1'b0;
    #1 chk("rst mid al_b", 32'(obs), 32'h0);
    ir_valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) begin
      chk("post rst idle", 32'(obs), 32'h0);
      tick();
    end
    run(16'h0000, 0, 0);

    run(16'h7000, 0, 0);
    run(16'hF000, 0, 1);
    run({4'($urandom_range(7, 14)), 12'($urandom)}, 0, 0);

    for (int n = 0; n < 60; n++)
      run({4'($urandom_range(0, 6)), 12'($urandom)},
          $urandom_range(0, 3), $urandom_range(0, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
